// File: rtl/apb_slave_mem.sv
// APB slave memory model: NUM_SLAVES one-hot selected banks of DEPTH words each,
// with byte strobes, a fixed number of wait states and an error response.
module apb_slave_mem #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int NUM_SLAVES  = 3,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic                    Hclk,
  input  logic                    Hreset,
  input  logic [NUM_SLAVES-1:0]   PSELx,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_W-1:0]       PADDR,
  input  logic [DATA_W-1:0]       PWDATA,
  input  logic [DATA_W/8-1:0]     PSTRB,
  output logic [DATA_W-1:0]       PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int BYTES  = DATA_W / 8;
  localparam int LSB    = $clog2(BYTES);
  localparam int WORD_W = $clog2(DEPTH);
  localparam int BANK_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [3:0] WAIT_MAX = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                  state_reg;
  logic [3:0]              cnt_reg;
  logic [NUM_SLAVES-1:0]   sel_reg;
  logic [ADDR_W-1:0]       addr_reg;
  logic                    write_reg;
  logic [DATA_W-1:0]       wdata_reg;
  logic [BYTES-1:0]        strb_reg;

  logic                    ready;
  logic                    err;
  logic                    commit;
  logic                    setup_req;
  logic                    latch_en;
  logic [BANK_W-1:0]       bank;
  logic [WORD_W-1:0]       word;
  logic [DATA_W-1:0]       bank_rdata [NUM_SLAVES];

  assign ready     = (state_reg == ACCESS) && (cnt_reg == WAIT_MAX);
  assign err       = !$onehot(sel_reg) || ((addr_reg >> (LSB + WORD_W)) != '0);
  assign commit    = ready && write_reg && !err;
  assign word      = addr_reg[LSB +: WORD_W];
  assign setup_req = (|PSELx) && !PENABLE;
  // A new transfer is captured from IDLE or, back-to-back, on the completing cycle.
  assign latch_en  = setup_req && ((state_reg == IDLE) || ready);

  always_comb begin
    bank = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (sel_reg[i]) bank = BANK_W'(i);
    end
  end

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (setup_req) state_reg <= SETUP;
        end
        SETUP: begin
          if (!(|PSELx)) begin
            state_reg <= IDLE;
          end else if (PENABLE) begin
            state_reg <= ACCESS;
            cnt_reg   <= '0;
          end
        end
        ACCESS: begin
          if (ready) begin
            state_reg <= setup_req ? SETUP : IDLE;
          end else if (!(|PSELx)) begin
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      sel_reg   <= '0;
      addr_reg  <= '0;
      write_reg <= 1'b0;
      wdata_reg <= '0;
      strb_reg  <= '0;
    end else if (latch_en) begin
      sel_reg   <= PSELx;
      addr_reg  <= PADDR;
      write_reg <= PWRITE;
      wdata_reg <= PWDATA;
      strb_reg  <= PSTRB;
    end
  end

  // One storage array per bank; cleared by reset, so it maps to registers.
  generate
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_bank
      logic [DATA_W-1:0] mem [DEPTH];

      always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
          for (int w = 0; w < DEPTH; w++) mem[w] <= '0;
        end else if (commit && (bank == BANK_W'(gi))) begin
          for (int b = 0; b < BYTES; b++) begin
            if (strb_reg[b]) mem[word][8*b +: 8] <= wdata_reg[8*b +: 8];
          end
        end
      end

      assign bank_rdata[gi] = mem[word];
    end
  endgenerate

  assign PREADY  = ready;
  assign PSLVERR = ready && err;
  assign PRDATA  = (ready && !write_reg && !err) ? bank_rdata[bank] : '0;

endmodule
